tok_receiver: RTL and testbench

- Receive end of the two-phase token ring whose start-up token is injected by the ring initializer.
- Synchronizes the asynchronous token level, detects arrivals (level transitions), and either holds the token for the local consumer or forwards it.
- Forwarding is a toggle on tok_out.
- Counts laps and runs a loss watchdog that requests ring re-initialization.

---
 rtl/tok_pkg.sv | 21 ++
 rtl/tok_sync.sv | 33 +++
 rtl/tok_receiver.sv | 188 ++++++++++++++++++
 tb/tb_tok_receiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tok_pkg.sv
// ---------------------------------------------------------------------------
// tok_pkg
// Shared definitions for the two-phase token ring receive node.
//   - FSM state encoding used by tok_receiver (2-bit constants).
//   - Default synchronizer depth, watchdog timeout and lap counter width,
//     shared with the ring initializer bench so both sides agree.
// ---------------------------------------------------------------------------
package tok_pkg;

  // Receiver FSM states
  localparam logic [1:0] ST_OFF  = 2'd0;  // node disabled, transparent forwarding
  localparam logic [1:0] ST_WAIT = 2'd1;  // waiting for the token, watchdog running
  localparam logic [1:0] ST_HOLD = 2'd2;  // token held for the local consumer
  localparam logic [1:0] ST_LOST = 2'd3;  // token declared lost, re-init requested

  // Defaults
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1024;
  localparam int DEF_CNT_W       = 8;

endpackage : tok_pkg

// File: rtl/tok_sync.sv
// ---------------------------------------------------------------------------
// tok_sync
// Multi-flop synchronizer bringing the asynchronous two-phase token level
// into the clk domain. All flops clear to 0 on reset.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   d      in  asynchronous level
//   q      out synchronized level (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module tok_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw level through the synchronizer chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule : tok_sync

// File: rtl/tok_receiver.sv
// ---------------------------------------------------------------------------
// tok_receiver
// Receive end of the two-phase token ring. Each level transition on tok_in
// is one token arrival. The node either holds the token for the local
// consumer or forwards it downstream by toggling tok_out. It counts laps and
// runs a watchdog that declares the token lost and asks the ring initializer
// to re-inject it.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   1 = participate, 0 = transparent forwarding only
//   tok_in      in   two-phase token from upstream (asynchronous)
//   hold_req    in   local consumer wants the token
//   tok_out     out  two-phase token to downstream (registered)
//   tok_have    out  token held locally
//   lap_count   out  arrivals seen while enabled, wrapping
//   tok_lost    out  token declared lost
//   reinit_req  out  one-cycle pulse on entering the lost state
//   dup_err     out  sticky: an arrival occurred while already holding
// ---------------------------------------------------------------------------
module tok_receiver
  import tok_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tok_in,
  input  logic             hold_req,
  output logic             tok_out,
  output logic             tok_have,
  output logic [CNT_W-1:0] lap_count,
  output logic             tok_lost,
  output logic             reinit_req,
  output logic             dup_err
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic             sync_s;
  logic             prev_r;
  logic             arr_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [TO_W-1:0]  wd_r;
  logic [TO_W-1:0]  wd_nxt_s;
  logic [CNT_W-1:0] lap_r;
  logic [CNT_W-1:0] lap_nxt_s;
  logic             tog_s;
  logic             dup_r;
  logic             dup_nxt_s;
  logic             tok_out_r;
  logic             tok_have_r;
  logic             tok_lost_r;
  logic             reinit_r;

  tok_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tok_in),
    .q     (sync_s)
  );

  // Any change of the synchronized level is one arrival
  assign arr_s = sync_s ^ prev_r;

  // Next-state, watchdog, lap counter and forward-toggle decisions
  always_comb begin
    state_nxt_s = state_r;
    wd_nxt_s    = wd_r;
    lap_nxt_s   = lap_r;
    tog_s       = 1'b0;
    dup_nxt_s   = dup_r;
    case (state_r)
      ST_WAIT: begin
        if (!enable) begin
          state_nxt_s = ST_OFF;
          wd_nxt_s    = '0;
          tog_s       = arr_s;
        end else if (arr_s) begin
          // An arrival beats a watchdog expiry in the same cycle
          lap_nxt_s = lap_r + CNT_W'(1);
          wd_nxt_s  = '0;
          if (hold_req) begin
            state_nxt_s = ST_HOLD;
          end else begin
            tog_s = 1'b1;
          end
        end else if (wd_r == TO_LAST) begin
          state_nxt_s = ST_LOST;
          wd_nxt_s    = '0;
        end else begin
          wd_nxt_s = wd_r + TO_W'(1);
        end
      end
      ST_HOLD: begin
        wd_nxt_s = '0;
        if (arr_s) begin
          dup_nxt_s = 1'b1;
          if (enable) begin
            lap_nxt_s = lap_r + CNT_W'(1);
          end else begin
            lap_nxt_s = lap_r;
          end
        end else begin
          dup_nxt_s = dup_r;
        end
        // Releasing the held token and forwarding a duplicate are each one
        // toggle; when both happen together they cancel out.
        if (!hold_req || !enable) begin
          tog_s       = ~arr_s;
          state_nxt_s = enable ? ST_WAIT : ST_OFF;
        end else begin
          tog_s = arr_s;
        end
      end
      ST_LOST: begin
        wd_nxt_s = '0;
        if (!enable) begin
          state_nxt_s = ST_OFF;
          tog_s       = arr_s;
        end else if (arr_s) begin
          lap_nxt_s = lap_r + CNT_W'(1);
          if (hold_req) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_WAIT;
            tog_s       = 1'b1;
          end
        end else begin
          state_nxt_s = ST_LOST;
        end
      end
      ST_OFF: begin
        wd_nxt_s = '0;
        tog_s    = arr_s;
        if (enable) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT;
        wd_nxt_s    = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r     <= 1'b0;
      state_r    <= ST_WAIT;
      wd_r       <= '0;
      lap_r      <= '0;
      dup_r      <= 1'b0;
      tok_out_r  <= 1'b0;
      tok_have_r <= 1'b0;
      tok_lost_r <= 1'b0;
      reinit_r   <= 1'b0;
    end else begin
      prev_r     <= sync_s;
      state_r    <= state_nxt_s;
      wd_r       <= wd_nxt_s;
      lap_r      <= lap_nxt_s;
      dup_r      <= dup_nxt_s;
      tok_out_r  <= tok_out_r ^ tog_s;
      tok_have_r <= (state_nxt_s == ST_HOLD);
      tok_lost_r <= (state_nxt_s == ST_LOST);
      reinit_r   <= (state_nxt_s == ST_LOST) && (state_r != ST_LOST);
    end
  end

  assign tok_out    = tok_out_r;
  assign tok_have   = tok_have_r;
  assign lap_count  = lap_r;
  assign tok_lost   = tok_lost_r;
  assign reinit_req = reinit_r;
  assign dup_err    = dup_r;

endmodule : tok_receiver

// File: tb/tb_tok_receiver.sv
// ---------------------------------------------------------------------------
// tb_tok_receiver
// Directed bench for tok_receiver (TIMEOUT=16, CNT_W=2): a per-cycle vector
// table for pass-through latency and a basic hold, then hand-written
// sequences for hold timing, watchdog expiry, lap wrap, disable, duplicate
// arrivals and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_tok_receiver;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tok_in;
  logic       hold_req;
  logic       tok_out;
  logic       tok_have;
  logic [1:0] lap_count;
  logic       tok_lost;
  logic       reinit_req;
  logic       dup_err;

  int passed;
  int total;
  int tog_cnt;
  logic last_out;

  typedef struct {
    logic       tin;
    logic       hold;
    logic       en;
    logic       e_out;
    logic       e_have;
    logic [1:0] e_lap;
    logic       e_lost;
  } vec_t;

  vec_t       vecs [11];
  logic [1:0] wrap_exp [5];

  tok_receiver #(
    .SYNC_STAGES (2),
    .TIMEOUT     (16),
    .CNT_W       (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tok_in     (tok_in),
    .hold_req   (hold_req),
    .tok_out    (tok_out),
    .tok_have   (tok_have),
    .lap_count  (lap_count),
    .tok_lost   (tok_lost),
    .reinit_req (reinit_req),
    .dup_err    (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance to the next falling edge(s), counting tok_out toggles on the way
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tok_out !== last_out) tog_cnt++;
      last_out = tok_out;
    end
  endtask

  initial begin
    logic       exp_out;
    logic [1:0] exp_lap;
    int         have_cnt;
    int         pulses;
    int         pulse_at;
    int         t0;
    logic       saved_out;

    passed = 0; total = 0; tog_cnt = 0; last_out = 1'b0;
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset state
    reset = 1'b0; enable = 1'b1; tok_in = 1'b0; hold_req = 1'b0;
    tick(2);
    chk("rst_tok_out", tok_out, 0);
    chk("rst_tok_have", tok_have, 0);
    chk("rst_lap", lap_count, 0);
    chk("rst_lost", tok_lost, 0);
    chk("rst_reinit", reinit_req, 0);
    chk("rst_dup", dup_err, 0);
    reset = 1'b1;

    // Vector table: 3-edge pass-through, then a short hold
    for (int k = 0; k < 11; k++) begin
      tok_in = vecs[k].tin; hold_req = vecs[k].hold; enable = vecs[k].en;
      tick(1);
      chk($sformatf("vec%0d_out", k), tok_out, vecs[k].e_out);
      chk($sformatf("vec%0d_have", k), tok_have, vecs[k].e_have);
      chk($sformatf("vec%0d_lap", k), lap_count, vecs[k].e_lap);
      chk($sformatf("vec%0d_lost", k), tok_lost, vecs[k].e_lost);
    end
    exp_out = 1'b0; exp_lap = 2'd2;

    // Four arrivals 10 cycles apart, the second held for 5 cycles
    t0 = tog_cnt;
    tok_in = ~tok_in; tick(10);
    exp_out = ~exp_out; exp_lap = exp_lap + 2'd1;
    chk("t2_arr1_out", tok_out, exp_out);
    tok_in = ~tok_in; hold_req = 1'b1; have_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (tok_have) have_cnt++;
      if (i == 6) hold_req = 1'b0;
    end
    exp_out = ~exp_out; exp_lap = exp_lap + 2'd1;
    chk("t2_have_cycles", have_cnt, 5);
    chk("t2_arr2_out", tok_out, exp_out);
    tok_in = ~tok_in; tick(10);
    tok_in = ~tok_in; tick(10);
    exp_lap = exp_lap + 2'd2;
    chk("t2_toggles", tog_cnt - t0, 4);
    chk("t2_lap", lap_count, exp_lap);
    chk("t2_out", tok_out, exp_out);

    // Watchdog expiry after an arrival, then recovery by the next arrival
    tok_in = ~tok_in; tick(3);
    exp_out = ~exp_out; exp_lap = exp_lap + 2'd1;
    chk("t3_fwd_out", tok_out, exp_out);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      if (reinit_req) begin pulses++; pulse_at = i; end
    end
    chk("t3_pulses", pulses, 1);
    chk("t3_pulse_at", pulse_at, 16);
    chk("t3_lost", tok_lost, 1);
    chk("t3_out_kept", tok_out, exp_out);
    tok_in = ~tok_in; tick(3);
    exp_out = ~exp_out; exp_lap = exp_lap + 2'd1;
    chk("t3_lost_clr", tok_lost, 0);
    chk("t3_lap", lap_count, exp_lap);
    chk("t3_out", tok_out, exp_out);

    // Fresh reset, lap wrap with a 2-bit counter, then disable while holding
    reset = 1'b0; tok_in = 1'b0; hold_req = 1'b0;
    tick(2);
    reset = 1'b1;
    exp_out = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tok_in = ~tok_in; tick(4);
      exp_out = ~exp_out;
      chk($sformatf("t5_lap%0d", j), lap_count, wrap_exp[j]);
      chk($sformatf("t5_out%0d", j), tok_out, exp_out);
    end
    hold_req = 1'b1; tok_in = ~tok_in; tick(3);
    chk("t5_have", tok_have, 1);
    chk("t5_hold_lap", lap_count, 2);
    enable = 1'b0; tick(1);
    exp_out = ~exp_out;
    chk("t5_off_release_out", tok_out, exp_out);
    chk("t5_off_release_have", tok_have, 0);
    hold_req = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tok_in = ~tok_in; tick(3);
      exp_out = ~exp_out;
      chk($sformatf("t5_off_fwd%0d", j), tok_out, exp_out);
      chk($sformatf("t5_off_lap%0d", j), lap_count, 2);
    end
    chk("t5_off_lost", tok_lost, 0);
    enable = 1'b1; tick(1);

    // Duplicate arrival while holding
    hold_req = 1'b1; tok_in = ~tok_in; tick(3);
    chk("t4_have", tok_have, 1);
    tick(2);
    t0 = tog_cnt;
    tok_in = ~tok_in; tick(3);
    chk("t4_dup", dup_err, 1);
    chk("t4_dup_toggles", tog_cnt - t0, 1);
    chk("t4_dup_have", tok_have, 1);
    tick(5);
    chk("t4_dup_sticky", dup_err, 1);
    exp_out = tok_out;
    hold_req = 1'b0; tick(1);
    exp_out = ~exp_out;
    chk("t4_release_out", tok_out, exp_out);
    chk("t4_release_have", tok_have, 0);
    chk("t4_dup_kept", dup_err, 1);

    // Release coinciding with a duplicate arrival: toggles cancel
    hold_req = 1'b1; tok_in = ~tok_in; tick(3);
    chk("t4c_have", tok_have, 1);
    tick(2);
    saved_out = exp_out;
    tok_in = ~tok_in; tick(2);
    hold_req = 1'b0; tick(1);
    chk("t4c_have_clr", tok_have, 0);
    chk("t4c_out_same", tok_out, saved_out);
    tick(1);

    // Asynchronous reset while holding, then watchdog restarts from 0
    hold_req = 1'b1; tok_in = ~tok_in; tick(3);
    chk("t6_have", tok_have, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_out", tok_out, 0);
    chk("t6_async_have", tok_have, 0);
    chk("t6_async_lap", lap_count, 0);
    chk("t6_async_lost", tok_lost, 0);
    chk("t6_async_reinit", reinit_req, 0);
    chk("t6_async_dup", dup_err, 0);
    tok_in = 1'b0; hold_req = 1'b0;
    tick(2);
    reset = 1'b1;
    pulse_at = 0; have_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      if (tok_have) have_cnt++;
      if (reinit_req && pulse_at == 0) pulse_at = i;
    end
    chk("t6_wd_restart", pulse_at, 16);
    chk("t6_no_hold", have_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_tok_receiver
